// File: rtl/ik_swift_csr_pkg.sv
// Shared register map, bit positions and FSM encoding for the ik_swift CSR bridge.
package ik_swift_csr_pkg;

  localparam logic [31:0] ADDR_CTRL   = 32'd0;
  localparam logic [31:0] ADDR_STATUS = 32'd1;
  localparam logic [31:0] ADDR_JTYPE  = 32'd2;
  localparam logic [31:0] ADDR_COUNT  = 32'd3;
  localparam logic [31:0] ADDR_ID     = 32'd4;
  localparam logic [31:0] ADDR_TARGET = 32'd8;
  localparam logic [31:0] ADDR_DH     = 32'd16;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_WR_ERR  = 3;

  localparam logic [15:0] ID_CODE = 16'h1C5B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int hi_w(input int word_w);
    return word_w - 32;
  endfunction

endpackage

// File: rtl/ik_swift_wide_reg.sv
// One WORD_W-wide register written as hi then lo; the lo write commits both halves
// in a single cycle so the consumer never sees a torn value.
module ik_swift_wide_reg
  import ik_swift_csr_pkg::*;
#(
  parameter int WORD_W = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              allow,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [31:0]       writedata,
  output logic [WORD_W-1:0] value
);

  localparam int HI_W = hi_w(WORD_W);

  logic [HI_W-1:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      value  <= '0;
    end else if (allow) begin
      if (hi_we) shadow <= writedata[HI_W-1:0];
      if (lo_we) value  <= {shadow, writedata};
    end
  end

endmodule

// File: rtl/ik_swift_csr_bridge.sv
// Avalon-MM slave staging targets/joint angles for the ik_swift core, with a
// start/busy/done FSM, timeout, cycle counter, interrupt and result snapshot.
module ik_swift_csr_bridge
  import ik_swift_csr_pkg::*;
#(
  parameter int NUM_JOINT   = 6,
  parameter int NUM_TARGET  = 3,
  parameter int WORD_W      = 36,
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         chipselect,
  input  logic                         write,
  input  logic [ADDR_W-1:0]            address,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic                         irq,
  output logic                         core_en,
  input  logic                         core_done,
  output logic [NUM_JOINT-1:0]         core_joint_type,
  output logic [NUM_TARGET*WORD_W-1:0] core_target,
  output logic [NUM_JOINT*WORD_W-1:0]  core_dh_in,
  input  logic [NUM_JOINT*WORD_W-1:0]  core_dh_out
);

  localparam int          HI_W = hi_w(WORD_W);
  localparam logic [31:0] NT   = 32'(NUM_TARGET);
  localparam logic [31:0] NJ   = 32'(NUM_JOINT);
  localparam logic [32:0] TMO  = 33'(TIMEOUT_CYC);

  state_t               state;
  logic                 done_f, timeout_f, wr_err_f, irq_en;
  logic [31:0]          count;
  logic [NUM_JOINT-1:0] joint_type;
  logic [HI_W-1:0]      rd_shadow;
  logic [WORD_W-1:0]    target_q [NUM_TARGET];
  logic [WORD_W-1:0]    dh_q     [NUM_JOINT];
  logic [WORD_W-1:0]    snap     [NUM_JOINT];

  logic        wr, rd, run, allow, is_hi, in_tgt, in_dh;
  logic        ctrl_wr, status_wr, jtype_wr, wr_blocked, tmo_hit;
  logic [31:0] addr32, tgt_idx, dh_idx;

  assign wr      = chipselect & write;
  assign rd      = chipselect & ~write;
  assign run     = (state == RUN);
  assign allow   = ~run;
  assign addr32  = 32'(address);
  assign is_hi   = ~address[0];
  assign tgt_idx = (addr32 - ADDR_TARGET) >> 1;
  assign dh_idx  = (addr32 - ADDR_DH) >> 1;
  // The target window ends where dh_in starts, so large NUM_TARGET cannot alias joints.
  assign in_tgt  = (addr32 >= ADDR_TARGET) && (addr32 < ADDR_DH) && (tgt_idx < NT);
  assign in_dh   = (addr32 >= ADDR_DH) && (dh_idx < NJ);

  assign ctrl_wr    = wr && (addr32 == ADDR_CTRL);
  assign status_wr  = wr && (addr32 == ADDR_STATUS);
  assign jtype_wr   = wr && (addr32 == ADDR_JTYPE);
  assign wr_blocked = run && (jtype_wr || (wr && (in_tgt || in_dh)));
  assign tmo_hit    = (TIMEOUT_CYC != 0) && (({1'b0, count} + 33'd1) >= TMO);

  assign irq             = done_f & irq_en;
  assign core_en         = run;
  assign core_joint_type = joint_type;

  for (genvar i = 0; i < NUM_TARGET; i++) begin : g_target
    ik_swift_wide_reg #(.WORD_W(WORD_W)) u_reg (
      .clk       (clk),
      .reset     (reset),
      .allow     (allow),
      .hi_we     (wr && in_tgt && (tgt_idx == i) && is_hi),
      .lo_we     (wr && in_tgt && (tgt_idx == i) && !is_hi),
      .writedata (writedata),
      .value     (target_q[i])
    );
    assign core_target[i*WORD_W +: WORD_W] = target_q[i];
  end

  for (genvar j = 0; j < NUM_JOINT; j++) begin : g_joint
    ik_swift_wide_reg #(.WORD_W(WORD_W)) u_reg (
      .clk       (clk),
      .reset     (reset),
      .allow     (allow),
      .hi_we     (wr && in_dh && (dh_idx == j) && is_hi),
      .lo_we     (wr && in_dh && (dh_idx == j) && !is_hi),
      .writedata (writedata),
      .value     (dh_q[j])
    );
    assign core_dh_in[j*WORD_W +: WORD_W] = dh_q[j];
  end

  // Flag clears go first so a same-cycle completion still wins over a W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done_f    <= 1'b0;
      timeout_f <= 1'b0;
      wr_err_f  <= 1'b0;
      irq_en    <= 1'b0;
      count     <= '0;
    end else begin
      if (ctrl_wr) irq_en <= writedata[CTRL_IRQ_EN];
      if (status_wr) begin
        if (writedata[ST_DONE])    done_f    <= 1'b0;
        if (writedata[ST_TIMEOUT]) timeout_f <= 1'b0;
        if (writedata[ST_WR_ERR])  wr_err_f  <= 1'b0;
      end
      if (wr_blocked) wr_err_f <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (ctrl_wr && writedata[CTRL_START]) begin
            state     <= RUN;
            done_f    <= 1'b0;
            timeout_f <= 1'b0;
            count     <= '0;
          end else if (state == DONE && status_wr && writedata[ST_DONE]) begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (count != '1) count <= count + 32'd1;
          if (core_done) begin
            state  <= DONE;
            done_f <= 1'b1;
          end else if (tmo_hit || (ctrl_wr && writedata[CTRL_ABORT])) begin
            state     <= DONE;
            done_f    <= 1'b1;
            timeout_f <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      joint_type <= '1;
    end else if (jtype_wr && allow) begin
      joint_type <= writedata[NUM_JOINT-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_JOINT; j++) snap[j] <= '0;
    end else if (run && core_done) begin
      for (int j = 0; j < NUM_JOINT; j++) snap[j] <= core_dh_out[j*WORD_W +: WORD_W];
    end
  end

  logic [WORD_W-1:0] tgt_sel, snap_sel;
  logic [31:0]       rd_word;
  logic [HI_W-1:0]   rd_hi;
  logic              rd_latch;

  always_comb begin
    tgt_sel  = '0;
    snap_sel = '0;
    for (int i = 0; i < NUM_TARGET; i++) if (tgt_idx == 32'(i)) tgt_sel = target_q[i];
    for (int j = 0; j < NUM_JOINT; j++) if (dh_idx == 32'(j)) snap_sel = snap[j];
  end

  // Lo reads latch the hi half so the hi read that follows pairs with the same value.
  always_comb begin
    rd_word  = '0;
    rd_hi    = '0;
    rd_latch = 1'b0;
    if (in_tgt || in_dh) begin
      if (is_hi) begin
        rd_word = 32'(rd_shadow);
      end else begin
        rd_latch = 1'b1;
        rd_word  = in_tgt ? tgt_sel[31:0] : snap_sel[31:0];
        rd_hi    = in_tgt ? tgt_sel[WORD_W-1:32] : snap_sel[WORD_W-1:32];
      end
    end else begin
      case (addr32)
        ADDR_STATUS: begin
          rd_word[ST_BUSY]    = run;
          rd_word[ST_DONE]    = done_f;
          rd_word[ST_TIMEOUT] = timeout_f;
          rd_word[ST_WR_ERR]  = wr_err_f;
        end
        ADDR_JTYPE: rd_word = 32'(joint_type);
        ADDR_COUNT: rd_word = count;
        ADDR_ID:    rd_word = {ID_CODE, 8'(NUM_TARGET), 8'(NUM_JOINT)};
        default:    rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata  <= '0;
      rd_shadow <= '0;
    end else if (rd) begin
      readdata <= rd_word;
      if (rd_latch) rd_shadow <= rd_hi;
    end
  end

endmodule

// File: tb/tb_ik_swift_csr_bridge.sv
// Bench for ik_swift_csr_bridge: default instance plus an 8-joint/48-bit instance
// with a short timeout; bus reads are scored against a queue of expected words.
module tb_ik_swift_csr_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [5:0]  address;
  logic [31:0] writedata;

  logic         cs_a, irq_a, en_a, cdone_a;
  logic [31:0]  rd_a;
  logic [5:0]   jt_a;
  logic [107:0] tgt_a;
  logic [215:0] dhin_a, dhout_a;

  logic         cs_b, irq_b, en_b, cdone_b;
  logic [31:0]  rd_b;
  logic [7:0]   jt_b;
  logic [143:0] tgt_b;
  logic [383:0] dhin_b, dhout_b;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  ik_swift_csr_bridge dut_a (
    .clk(clk), .reset(reset), .chipselect(cs_a), .write(write), .address(address),
    .writedata(writedata), .readdata(rd_a), .irq(irq_a), .core_en(en_a),
    .core_done(cdone_a), .core_joint_type(jt_a), .core_target(tgt_a),
    .core_dh_in(dhin_a), .core_dh_out(dhout_a)
  );

  ik_swift_csr_bridge #(.NUM_JOINT(8), .NUM_TARGET(3), .WORD_W(48), .ADDR_W(6),
                        .TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .reset(reset), .chipselect(cs_b), .write(write), .address(address),
    .writedata(writedata), .readdata(rd_b), .irq(irq_b), .core_en(en_b),
    .core_done(cdone_b), .core_joint_type(jt_b), .core_target(tgt_b),
    .core_dh_in(dhin_b), .core_dh_out(dhout_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input bit b, input int a, input logic [31:0] d);
    cs_a = !b; cs_b = b; write = 1'b1; address = 6'(a); writedata = d;
    @(posedge clk); #1;
    cs_a = 1'b0; cs_b = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input bit b, input int a, input logic [31:0] exp, input string tag);
    cs_a = !b; cs_b = b; write = 1'b0; address = 6'(a);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    cs_a = 1'b0; cs_b = 1'b0;
    check(tag_q.pop_front(), 64'(b ? rd_b : rd_a), 64'(exp_q.pop_front()));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; write = 1'b0; address = '0; writedata = '0;
    cs_a = 1'b0; cs_b = 1'b0; cdone_a = 1'b0; cdone_b = 1'b0;
    dhout_a = '0; dhout_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    check("rst_core_en", 64'(en_a), 64'd0);
    check("rst_irq", 64'(irq_a), 64'd0);
    check("rst_jt_port", 64'(jt_a), 64'h3F);
    bus_rd(0, 2, 32'h3F, "rst_jtype");
    bus_rd(0, 1, 32'h0, "rst_status");
    bus_rd(0, 3, 32'h0, "rst_count");
    bus_rd(0, 4, {16'h1C5B, 8'd3, 8'd6}, "id_a");
    bus_rd(0, 5, 32'h0, "unmapped_5");
    bus_rd(0, 40, 32'h0, "unmapped_40");

    // tear-free dh_in writes
    bus_wr(0, 17, 32'h5);
    check("dh0_lo5", 64'(dhin_a[35:0]), 64'h5);
    bus_wr(0, 17, 32'h0);
    check("dh0_lo0", 64'(dhin_a[35:0]), 64'h0);
    bus_wr(0, 16, 32'h3);
    check("dh0_hi_only", 64'(dhin_a[35:0]), 64'h0);
    bus_wr(0, 17, 32'h10000);
    check("dh0_commit", 64'(dhin_a[35:0]), 64'h3_0001_0000);
    bus_wr(0, 26, 32'hA);
    bus_wr(0, 27, 32'h1234_5678);
    check("dh5_commit", 64'(dhin_a[5*36 +: 36]), 64'hA_1234_5678);
    check("dh0_kept", 64'(dhin_a[35:0]), 64'h3_0001_0000);

    // run to completion, core_done on the 40th RUN cycle
    dhout_a[0 +: 36]    = 36'h1_2345_6789;
    dhout_a[2*36 +: 36] = 36'hF_FFFF_0000;
    bus_wr(0, 0, 32'h3);
    check("run_core_en", 64'(en_a), 64'd1);
    bus_rd(0, 1, 32'h1, "run_busy");
    repeat (38) @(posedge clk);
    #1 cdone_a = 1'b1;
    @(posedge clk); #1 cdone_a = 1'b0;
    check("done_core_en", 64'(en_a), 64'd0);
    check("done_irq", 64'(irq_a), 64'd1);
    dhout_a = '0;
    bus_rd(0, 1, 32'h2, "done_status");
    bus_rd(0, 3, 32'd40, "done_count");
    bus_rd(0, 21, 32'hFFFF_0000, "snap2_lo");
    bus_rd(0, 20, 32'hF, "snap2_hi");
    bus_rd(0, 17, 32'h2345_6789, "snap0_lo");
    bus_rd(0, 16, 32'h1, "snap0_hi");
    bus_wr(0, 1, 32'h2);
    check("w1c_irq", 64'(irq_a), 64'd0);
    bus_rd(0, 1, 32'h0, "w1c_status");
    bus_rd(0, 3, 32'd40, "idle_count");

    // writes during RUN are dropped and flag wr_err
    bus_wr(0, 8, 32'h7);
    bus_wr(0, 9, 32'hDEAD_BEEF);
    check("tgt0_idle", 64'(tgt_a[35:0]), 64'h7_DEAD_BEEF);
    bus_wr(0, 0, 32'h1);
    bus_wr(0, 8, 32'h1);
    bus_wr(0, 9, 32'h0);
    check("tgt0_locked", 64'(tgt_a[35:0]), 64'h7_DEAD_BEEF);
    bus_wr(0, 2, 32'h0);
    check("jt_locked", 64'(jt_a), 64'h3F);
    bus_rd(0, 1, 32'h9, "wr_err_set");
    bus_wr(0, 1, 32'h8);
    bus_rd(0, 1, 32'h1, "wr_err_clr");
    bus_wr(0, 0, 32'h4);
    bus_rd(0, 1, 32'h6, "abort_status");
    check("abort_irq_masked", 64'(irq_a), 64'd0);
    bus_rd(0, 21, 32'hFFFF_0000, "abort_snap_kept");
    bus_wr(0, 1, 32'h6);
    bus_rd(0, 1, 32'h0, "abort_cleared");
    bus_wr(0, 9, 32'h1111_1111);
    check("tgt0_shadow_kept", 64'(tgt_a[35:0]), 64'h7_1111_1111);

    // reset mid-RUN
    bus_wr(0, 0, 32'h3);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_run_core_en", 64'(en_a), 64'd0);
    check("rst_run_irq", 64'(irq_a), 64'd0);
    reset = 1'b0;
    bus_rd(0, 1, 32'h0, "rst_run_status");
    check("rst_tgt_zero", 64'(|tgt_a), 64'd0);
    check("rst_dh_zero", 64'(|dhin_a), 64'd0);
    bus_rd(0, 21, 32'h0, "rst_snap_lo");
    bus_rd(0, 20, 32'h0, "rst_snap_hi");

    // 48-bit, 8-joint instance: completion then timeout
    bus_rd(1, 4, {16'h1C5B, 8'd3, 8'd8}, "id_b");
    dhout_b[7*48 +: 48] = 48'hABCD_0123_4567;
    bus_wr(1, 0, 32'h1);
    cdone_b = 1'b1;
    @(posedge clk); #1 cdone_b = 1'b0;
    bus_rd(1, 3, 32'd1, "b_count1");
    bus_wr(1, 1, 32'h2);
    dhout_b[7*48 +: 48] = 48'h1111_2222_3333;
    bus_wr(1, 0, 32'h3);
    repeat (15) @(posedge clk);
    #1 check("tmo_not_yet", 64'(en_b), 64'd1);
    @(posedge clk); #1;
    check("tmo_core_en", 64'(en_b), 64'd0);
    check("tmo_irq", 64'(irq_b), 64'd1);
    bus_rd(1, 1, 32'h6, "tmo_status");
    bus_rd(1, 3, 32'd16, "tmo_count");
    bus_rd(1, 31, 32'h0123_4567, "tmo_snap7_lo");
    bus_rd(1, 30, 32'hABCD, "tmo_snap7_hi");

    bus_wr(1, 30, 32'hBEEF);
    bus_wr(1, 31, 32'hCAFE_0001);
    check("b_dh7_commit", 64'(dhin_b[7*48 +: 48]), 64'hBEEF_CAFE_0001);
    bus_wr(1, 0, 32'h1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("b_rst_core_en", 64'(en_b), 64'd0);
    reset = 1'b0;
    bus_rd(1, 1, 32'h0, "b_rst_status");
    check("b_rst_dh_zero", 64'(|dhin_b), 64'd0);
    bus_rd(1, 2, 32'hFF, "b_rst_jtype");
    bus_rd(1, 31, 32'h0, "b_rst_snap7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
